// File: rtl/rns_pkg.sv
// Shared RNS definitions: default lane geometry (also used by the CRT stage),
// decomposer FSM encoding and a packed-lane slice helper.
package rns_pkg;

  localparam int RNS_NUM_MODULI  = 4;
  localparam int RNS_MOD_WIDTH   = 4;
  localparam int RNS_VALUE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Lane 0 sits in the LSBs of a packed moduli/residue vector.
  function automatic logic [RNS_MOD_WIDTH-1:0] lane_slice(
    input logic [RNS_NUM_MODULI*RNS_MOD_WIDTH-1:0] vec,
    input int unsigned                             lane
  );
    return vec[lane*RNS_MOD_WIDTH +: RNS_MOD_WIDTH];
  endfunction

endpackage

// File: rtl/rns_mod_step.sv
// One restoring-remainder step: shift in one dividend bit, subtract the
// modulus if it fits. A zero modulus yields 0 without comparing.
module rns_mod_step #(
  parameter int MOD_WIDTH = 4
) (
  input  logic [MOD_WIDTH:0]   rem_i,
  input  logic                 bit_i,
  input  logic [MOD_WIDTH-1:0] mod_i,
  output logic [MOD_WIDTH:0]   rem_o
);

  logic [MOD_WIDTH:0] t;
  logic [MOD_WIDTH:0] mod_ext;

  // rem_i < mod_i always holds, so t < 2*mod_i fits MOD_WIDTH+1 bits.
  assign t       = (rem_i << 1) | {{MOD_WIDTH{1'b0}}, bit_i};
  assign mod_ext = {1'b0, mod_i};

  always_comb begin
    rem_o = t;
    if (mod_i == '0) begin
      rem_o = '0;
    end else if (t >= mod_ext) begin
      rem_o = t - mod_ext;
    end
  end

endmodule

// File: rtl/rns_residue_decomposer.sv
// Forward RNS conversion: X mod m_i for each lane, one dividend bit per cycle.
// Optional RNS_DECOMP_ZERO_MOD_ERR_EN adds an err flag for zero moduli.
module rns_residue_decomposer
  import rns_pkg::*;
#(
  parameter int NUM_MODULI  = RNS_NUM_MODULI,
  parameter int MOD_WIDTH   = RNS_MOD_WIDTH,
  parameter int VALUE_WIDTH = RNS_VALUE_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [VALUE_WIDTH-1:0]          value,
  input  logic [NUM_MODULI*MOD_WIDTH-1:0] m,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef RNS_DECOMP_ZERO_MOD_ERR_EN
  output logic                            err,
`endif
  output logic [NUM_MODULI*MOD_WIDTH-1:0] residues
);

  localparam int PW = NUM_MODULI * MOD_WIDTH;
  localparam int LW = (NUM_MODULI > 1) ? $clog2(NUM_MODULI) : 1;
  localparam int BW = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
  localparam logic [LW-1:0] LANE_MAX = LW'(NUM_MODULI - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(VALUE_WIDTH - 1);

  state_t                 state_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [PW-1:0]          m_q;
  logic [PW-1:0]          residues_q;
  logic [LW-1:0]          lane_q;
  logic [BW-1:0]          bit_q;
  logic [MOD_WIDTH:0]     rem_q;
  logic [MOD_WIDTH:0]     rem_d;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [MOD_WIDTH-1:0]   m_lane [NUM_MODULI];

  for (genvar gi = 0; gi < NUM_MODULI; gi++) begin : g_lane
    assign m_lane[gi] = m_q[gi*MOD_WIDTH +: MOD_WIDTH];
  end

`ifdef RNS_DECOMP_ZERO_MOD_ERR_EN
  logic                  err_q;
  logic [NUM_MODULI-1:0] zero_lane;
  for (genvar gi = 0; gi < NUM_MODULI; gi++) begin : g_zero
    assign zero_lane[gi] = (m_lane[gi] == '0);
  end
  assign err = err_q;
`endif

  rns_mod_step #(.MOD_WIDTH(MOD_WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (value_q[bit_q]),
    .mod_i (m_lane[lane_q]),
    .rem_o (rem_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      m_q         <= '0;
      residues_q  <= '0;
      lane_q      <= '0;
      bit_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef RNS_DECOMP_ZERO_MOD_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            value_q    <= value;
            m_q        <= m;
            lane_q     <= '0;
            bit_q      <= BIT_MAX;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= REDUCE;
          end
        end
        REDUCE: begin
          if (bit_q == '0) begin
            // Last bit of this lane: commit the finished remainder.
            residues_q[lane_q*MOD_WIDTH +: MOD_WIDTH] <= rem_d[MOD_WIDTH-1:0];
            rem_q  <= '0;
            bit_q  <= BIT_MAX;
            lane_q <= lane_q + 1'b1;
            if (lane_q == LANE_MAX) begin
              out_valid_q <= 1'b1;
              state_q     <= DONE;
`ifdef RNS_DECOMP_ZERO_MOD_ERR_EN
              err_q       <= |zero_lane;
`endif
            end
          end else begin
            rem_q <= rem_d;
            bit_q <= bit_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
`ifdef RNS_DECOMP_ZERO_MOD_ERR_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign residues  = residues_q;

endmodule
